redun_mont_sq_seq: RTL and testbench
====================================

# redun_mont_sq_seq

- Iterated Montgomery multiply sequencer for the VDF datapath.
- Accepts a start value in redundant Montgomery form and an iteration count T, then drives an external `redun_mont` multiplier T times, feeding each product back as the next operand.
- Returns the final product with a valid/ready handshake.
- Generalises single-shot squaring: parametrised width and count, square or multiply-by-constant mode, variable multiplier latency, overflow abort.

## Interface
- `P_W`, 1024 — redundant operand width in bits (`redun0_t` width in the design).
- `P_IW`, 32 — iteration counter width.
- `P_CHK`, 1024 — checkpoint interval in iterations (used only with the checkpoint macro).
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_start_val`  in  1  start request.
- `o_start_rdy`  out  1  high only in IDLE.
- `i_start_a`  in  P_W  start operand, redundant Montgomery form.
- `i_start_b`  in  P_W  fixed operand for multiply mode.
- `i_mode`  in  1  0 = square (a·a), 1 = multiply (a·b).
- `i_iter`  in  P_IW  iteration count T.
- `o_mul_a`, `o_mul_b`  out  P_W  multiplier operands.
- `o_mul_val`  out  1  one-cycle issue pulse.
- `i_mul_res`  in  P_W  multiplier product.
- `i_mul_val`  in  1  product valid.
- `i_mul_ovf`  in  1  multiplier overflow flag, qualified by `i_mul_val`.
- `o_res_val`  out  1  result valid.
- `i_res_rdy`  in  1  result accepted.
- `o_res_data`  out  P_W  final product.
- `o_res_err`  out  1  run aborted on overflow.
- `o_iter_done`  out  P_IW  completed iterations.
- `o_busy`  out  1  state ≠ IDLE.
- `o_chk_val`  out  1  checkpoint pulse.
- `o_chk_data`  out  P_W  checkpoint value.
- `o_chk_idx`  out  P_IW  checkpoint iteration.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On `i_start_val & o_start_rdy`: latch A ← `i_start_a`, B ← `i_start_b`, mode, T; clear counter and error.
  - If T = 0, go to DONE with `o_res_data` = A. Otherwise go to ISSUE.
- **ISSUE** (one cycle)
  - `o_mul_val` = 1.
  - `o_mul_a` = A.
  - `o_mul_b` = A when square mode, B when multiply mode.
  - Go to WAIT.
- **WAIT**
  - Hold operands; `o_mul_val` = 0.
  - On `i_mul_val`: A ← `i_mul_res`, counter += 1.
  - If `i_mul_ovf`: set `o_res_err` and go to DONE.
  - Else if counter+1 = T: go to DONE.
  - Else: go to ISSUE.
- **DONE**
  - `o_res_val` = 1, `o_res_data` = A.
  - Data stable while `i_res_rdy` = 0.
  - On `i_res_rdy`: go to IDLE. `o_res_err` and `o_iter_done` hold until the next start.
- `i_mul_val` outside WAIT is ignored.
- Counter compare is exact at width P_IW. T = 2^P_IW−1 is legal; the counter never wraps within a run.
- `i_start_val` outside IDLE is ignored; no queueing.

## Timing
- Reset: all outputs 0 and state IDLE; `o_start_rdy` rises on the first clock after deassertion. Reset mid-run aborts with no result.
- Start accepted at edge 0; ISSUE occupies cycle 1.
- With multiplier latency L (`o_mul_val` to `i_mul_val`, L ≥ 1), the product of iteration k arrives in cycle k·(L+1).
- `o_res_val` rises in cycle T·(L+1)+1. For T = 0 it rises in cycle 1.
- All outputs are registered.

## Configuration
- Macro: `REDUN_MONT_SEQ_CHECKPOINT_EN`.
- **Defined:**
  - When the counter reaches a nonzero multiple of P_CHK on a product update, `o_chk_val` pulses for one cycle, the cycle after the `i_mul_val` that produced it.
  - `o_chk_data` = new A, `o_chk_idx` = counter.
  - No back-pressure.
- **Undefined:** the `o_chk_*` ports remain but are tied to 0, and no checkpoint logic is built.

## Structure
- Shared package `redun_mont_seq_pkg`:
  - state enum;
  - iteration-count typedef;
  - mode constants MODE_SQ = 0 and MODE_MUL = 1.
- The operand type `redun0_t` and the helpers `to_redun`, `from_redun`, `to_mont`, `fe_mul_mont` are reused from the existing packages.
- No sub-module in the sequencer. The bench connects it to `redun_mont`, or to a fixed-latency behavioural model.

## Test plan
- **T = 0:** A = `to_redun(to_mont(2))`, T = 0.
  - `o_res_val` in cycle 1 with `o_res_data` = A.
  - `o_mul_val` never asserts.
- **Square run:** square mode, T = 10, model L = 4.
  - `o_res_val` in cycle 51.
  - `from_redun(o_res_data)` equals ten chained `fe_mul_mont` squarings of `to_mont(2)`.
  - `o_iter_done` = 10.
- **Multiply run:** multiply mode, A = `to_mont(2)`, B = `to_mont(3)`, T = 3.
  - `from_redun(o_res_data)` = `to_mont(54)`.
- **Overflow abort:** `i_mul_ovf` = 1 on the 2nd product, T = 8.
  - DONE reached with `o_res_err` = 1, `o_iter_done` = 2.
  - No further `o_mul_val`.
- **Back-pressure and reset:**
  - Hold `i_res_rdy` = 0 for 5 cycles: `o_res_val`/`o_res_data` stable, `o_start_rdy` = 0.
  - Assert `i_rst_n` = 0 in WAIT: outputs go to 0 immediately, and a late `i_mul_val` after release is ignored.
- **Checkpoints:** `REDUN_MONT_SEQ_CHECKPOINT_EN` defined, P_CHK = 4, T = 10.
  - `o_chk_val` pulses exactly twice, with `o_chk_idx` = 4 and 8 and matching model values.

Source files
------------

// File: rtl/redun_mont_seq_pkg.sv
// rtl/redun_mont_seq_pkg.sv - shared types and constants for the iterated Montgomery sequencer
package redun_mont_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ITER_W = 32;
  typedef logic [ITER_W-1:0] iter_t;

  localparam logic MODE_SQ  = 1'b0;
  localparam logic MODE_MUL = 1'b1;

endpackage

// File: rtl/redun_mont_sq_seq.sv
// rtl/redun_mont_sq_seq.sv - iterated Montgomery multiply sequencer driving an external redun_mont
// Optional checkpoint outputs built only when REDUN_MONT_SEQ_CHECKPOINT_EN is defined.
module redun_mont_sq_seq
  import redun_mont_seq_pkg::*;
#(
  parameter int P_W   = 1024,
  parameter int P_IW  = 32,
  parameter int P_CHK = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start_val,
  output logic            o_start_rdy,
  input  logic [P_W-1:0]  i_start_a,
  input  logic [P_W-1:0]  i_start_b,
  input  logic            i_mode,
  input  logic [P_IW-1:0] i_iter,
  output logic [P_W-1:0]  o_mul_a,
  output logic [P_W-1:0]  o_mul_b,
  output logic            o_mul_val,
  input  logic [P_W-1:0]  i_mul_res,
  input  logic            i_mul_val,
  input  logic            i_mul_ovf,
  output logic            o_res_val,
  input  logic            i_res_rdy,
  output logic [P_W-1:0]  o_res_data,
  output logic            o_res_err,
  output logic [P_IW-1:0] o_iter_done,
  output logic            o_busy,
  output logic            o_chk_val,
  output logic [P_W-1:0]  o_chk_data,
  output logic [P_IW-1:0] o_chk_idx
);

  if (P_CHK < 1 || P_IW < 1 || P_W < 1) begin : g_param_chk
    $error("redun_mont_sq_seq: P_W, P_IW and P_CHK must all be at least 1");
  end

  state_t          state_q, state_n;
  logic [P_W-1:0]  a_q, a_n, b_q, b_n;
  logic [P_IW-1:0] t_q, cnt_q, cnt_n;
  logic            mode_q, mode_n;
  logic            err_n;
  logic            accept;

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    cnt_n   = cnt_q;
    err_n   = o_res_err;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start_val && o_start_rdy) begin
          accept  = 1'b1;
          a_n     = i_start_a;
          cnt_n   = '0;
          err_n   = 1'b0;
          state_n = (i_iter == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (i_mul_val) begin
          a_n   = i_mul_res;
          cnt_n = cnt_q + 1'b1;
          if (i_mul_ovf) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else if (cnt_n == t_q) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      DONE: begin
        if (i_res_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    b_n    = accept ? i_start_b : b_q;
    mode_n = accept ? i_mode : mode_q;
  end

  // Outputs are loaded from the next-state decode so every port is a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      t_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= MODE_SQ;
      o_res_err   <= 1'b0;
      o_start_rdy <= 1'b0;
      o_busy      <= 1'b0;
      o_mul_val   <= 1'b0;
      o_mul_a     <= '0;
      o_mul_b     <= '0;
      o_res_val   <= 1'b0;
      o_res_data  <= '0;
    end else begin
      state_q     <= state_n;
      a_q         <= a_n;
      b_q         <= b_n;
      cnt_q       <= cnt_n;
      mode_q      <= mode_n;
      o_res_err   <= err_n;
      if (accept) t_q <= i_iter;
      o_start_rdy <= (state_n == IDLE);
      o_busy      <= (state_n != IDLE);
      o_mul_val   <= (state_n == ISSUE);
      if (state_n == ISSUE) begin
        o_mul_a <= a_n;
        o_mul_b <= (mode_n == MODE_MUL) ? b_n : a_n;
      end
      o_res_val <= (state_n == DONE);
      if (state_n == DONE) o_res_data <= a_n;
    end
  end

  assign o_iter_done = cnt_q;

`ifdef REDUN_MONT_SEQ_CHECKPOINT_EN
  localparam logic [P_IW-1:0] CHK_LAST = P_IW'(P_CHK - 1);

  // Phase counter avoids a modulo on the iteration count.
  logic [P_IW-1:0] chk_ph_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chk_ph_q   <= '0;
      o_chk_val  <= 1'b0;
      o_chk_data <= '0;
      o_chk_idx  <= '0;
    end else begin
      o_chk_val <= 1'b0;
      if (accept) begin
        chk_ph_q <= '0;
      end else if (state_q == WAIT && i_mul_val) begin
        if (chk_ph_q == CHK_LAST) begin
          chk_ph_q   <= '0;
          o_chk_val  <= 1'b1;
          o_chk_data <= i_mul_res;
          o_chk_idx  <= cnt_n;
        end else begin
          chk_ph_q <= chk_ph_q + 1'b1;
        end
      end
    end
  end
`else
  assign o_chk_val  = 1'b0;
  assign o_chk_data = '0;
  assign o_chk_idx  = '0;
`endif

endmodule

// File: tb/tb_redun_mont_sq_seq.sv
// tb/tb_redun_mont_sq_seq.sv - directed bench for redun_mont_sq_seq with a fixed-latency Montgomery model
module tb_redun_mont_sq_seq;

  localparam int W   = 32;
  localparam int IW  = 8;
  localparam int CHK = 4;
  localparam longint unsigned P = 65521;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start_val = 1'b0;
  logic          o_start_rdy;
  logic [W-1:0]  i_start_a = '0;
  logic [W-1:0]  i_start_b = '0;
  logic          i_mode = 1'b0;
  logic [IW-1:0] i_iter = '0;
  logic [W-1:0]  o_mul_a, o_mul_b;
  logic          o_mul_val;
  logic [W-1:0]  i_mul_res = '0;
  logic          i_mul_val = 1'b0;
  logic          i_mul_ovf = 1'b0;
  logic          o_res_val;
  logic          i_res_rdy = 1'b0;
  logic [W-1:0]  o_res_data;
  logic          o_res_err;
  logic [IW-1:0] o_iter_done;
  logic          o_busy;
  logic          o_chk_val;
  logic [W-1:0]  o_chk_data;
  logic [IW-1:0] o_chk_idx;

  int n_checks = 0;
  int n_fail   = 0;

  int lat    = 4;
  int ovf_at = 0;

  always #5 i_clk = ~i_clk;

  redun_mont_sq_seq #(.P_W(W), .P_IW(IW), .P_CHK(CHK)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_start_val(i_start_val), .o_start_rdy(o_start_rdy),
    .i_start_a(i_start_a), .i_start_b(i_start_b), .i_mode(i_mode), .i_iter(i_iter),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .o_mul_val(o_mul_val),
    .i_mul_res(i_mul_res), .i_mul_val(i_mul_val), .i_mul_ovf(i_mul_ovf),
    .o_res_val(o_res_val), .i_res_rdy(i_res_rdy), .o_res_data(o_res_data),
    .o_res_err(o_res_err), .o_iter_done(o_iter_done), .o_busy(o_busy),
    .o_chk_val(o_chk_val), .o_chk_data(o_chk_data), .o_chk_idx(o_chk_idx)
  );

  // Montgomery arithmetic mod P with R = 2^16; redundant form is the plain residue here.
  function automatic logic [W-1:0] fe_mul_mont(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] t;
    t = 64'(a) * 64'(b);
    for (int i = 0; i < 16; i++) begin
      if (t[0]) t = t + 64'(P);
      t = t >> 1;
    end
    if (t >= 64'(P)) t = t - 64'(P);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] to_mont(input longint unsigned x);
    logic [63:0] t;
    t = (64'(x) << 16) % 64'(P);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] to_redun(input logic [W-1:0] x);
    return x;
  endfunction

  function automatic logic [W-1:0] from_redun(input logic [W-1:0] x);
    logic [63:0] t;
    t = 64'(x) % 64'(P);
    return t[W-1:0];
  endfunction

  function automatic longint unsigned pow2(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = (r * 2) % P;
    return r;
  endfunction

  // Behavioural multiplier: product appears lat cycles after the issue pulse.
  logic          m_pend = 1'b0;
  int            m_left = 0;
  int            m_nprod = 0;
  logic [W-1:0]  m_res = '0;
  logic          m_ovf = 1'b0;

  always @(posedge i_clk) begin
    logic          iss, hs;
    logic [W-1:0]  ma, mb;
    iss = o_mul_val;
    hs  = i_start_val && o_start_rdy;
    ma  = o_mul_a;
    mb  = o_mul_b;
    #1;
    i_mul_val = 1'b0;
    i_mul_ovf = 1'b0;
    if (hs) m_nprod = 0;
    if (iss) begin
      m_nprod = m_nprod + 1;
      m_pend  = 1'b1;
      m_left  = lat;
      m_res   = fe_mul_mont(ma, mb);
      m_ovf   = (m_nprod == ovf_at);
    end
    if (m_pend) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        i_mul_val = 1'b1;
        i_mul_res = m_res;
        i_mul_ovf = m_ovf;
        m_pend    = 1'b0;
      end
    end
  end

  int           chk_cnt;
  int           chk_bad;
  logic [IW-1:0] chk_idx [2];
  logic [W-1:0]  chk_dat [2];

  task automatic start_run(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [IW-1:0] t, input int l, input int ovf);
    @(negedge i_clk);
    lat = l;
    ovf_at = ovf;
    i_mode = mode;
    i_start_a = a;
    i_start_b = b;
    i_iter = t;
    i_start_val = 1'b1;
    @(posedge i_clk);
    #1 i_start_val = 1'b0;
  endtask

  task automatic wait_done(output int rise, output int pulses);
    logic prev_mv;
    rise = -1;
    pulses = 0;
    chk_cnt = 0;
    chk_bad = 0;
    prev_mv = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge i_clk);
      if (o_mul_val) pulses++;
      if (o_chk_val) begin
        if (!prev_mv) chk_bad++;
        if (chk_cnt < 2) begin
          chk_idx[chk_cnt] = o_chk_idx;
          chk_dat[chk_cnt] = o_chk_data;
        end
        chk_cnt++;
      end
      prev_mv = i_mul_val;
      if (o_res_val) begin
        rise = c;
        break;
      end
    end
    if (rise < 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: o_res_val not seen within 3000 cycles");
    end
  endtask

  task automatic accept_result();
    @(negedge i_clk);
    i_res_rdy = 1'b1;
    @(posedge i_clk);
    #1 i_res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({o_start_rdy, o_busy, o_mul_val, o_res_val, o_res_err, o_chk_val} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {o_start_rdy, o_busy, o_mul_val, o_res_val, o_res_err, o_chk_val});
    end
    n_checks++;
    if ({o_mul_a, o_mul_b, o_res_data, o_iter_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: mul_a=%h mul_b=%h res=%h iter=%0d want all 0",
               o_mul_a, o_mul_b, o_res_data, o_iter_done);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    n_checks++;
    if (o_start_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rdy_before_clk: got %b want 0", o_start_rdy);
    end
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_start_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rdy_after_clk: got %b want 1", o_start_rdy);
    end
  endtask

  task automatic test_t0();
    int rise, pulses;
    logic [W-1:0] a;
    a = to_redun(to_mont(2));
    start_run(1'b0, a, '0, 8'd0, 4, 0);
    wait_done(rise, pulses);
    n_checks++;
    if (rise !== 1) begin n_fail++; $display("FAIL t0_cycle: got %0d want 1", rise); end
    n_checks++;
    if (o_res_data !== a) begin n_fail++; $display("FAIL t0_data: got %h want %h", o_res_data, a); end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL t0_mul_val: got %0d pulses want 0", pulses); end
    accept_result();
  endtask

  task automatic test_square();
    int rise, pulses;
    logic [W-1:0] exp_res;
    exp_res = to_mont(pow2(1024));
    start_run(1'b0, to_redun(to_mont(2)), '0, 8'd10, 4, 0);
    wait_done(rise, pulses);
    n_checks++;
    if (rise !== 51) begin n_fail++; $display("FAIL sq_cycle: got %0d want 51", rise); end
    n_checks++;
    if (from_redun(o_res_data) !== exp_res) begin
      n_fail++; $display("FAIL sq_data: got %h want %h", from_redun(o_res_data), exp_res);
    end
    n_checks++;
    if (o_iter_done !== 8'd10) begin n_fail++; $display("FAIL sq_iter: got %0d want 10", o_iter_done); end
    n_checks++;
    if (pulses !== 10) begin n_fail++; $display("FAIL sq_pulses: got %0d want 10", pulses); end
`ifdef REDUN_MONT_SEQ_CHECKPOINT_EN
    n_checks++;
    if (chk_cnt !== 2) begin n_fail++; $display("FAIL chk_count: got %0d want 2", chk_cnt); end
    n_checks++;
    if (chk_bad !== 0) begin n_fail++; $display("FAIL chk_timing: got %0d misplaced pulses want 0", chk_bad); end
    n_checks++;
    if (chk_idx[0] !== 8'd4 || chk_idx[1] !== 8'd8) begin
      n_fail++; $display("FAIL chk_idx: got %0d,%0d want 4,8", chk_idx[0], chk_idx[1]);
    end
    n_checks++;
    if (from_redun(chk_dat[0]) !== to_mont(pow2(16)) || from_redun(chk_dat[1]) !== to_mont(pow2(256))) begin
      n_fail++; $display("FAIL chk_data: got %h,%h want %h,%h", chk_dat[0], chk_dat[1],
                         to_mont(pow2(16)), to_mont(pow2(256)));
    end
`else
    n_checks++;
    if (chk_cnt !== 0 || o_chk_data !== '0 || o_chk_idx !== '0) begin
      n_fail++; $display("FAIL chk_tied: got pulses=%0d data=%h idx=%0d want 0", chk_cnt, o_chk_data, o_chk_idx);
    end
`endif
    accept_result();
  endtask

  task automatic test_multiply();
    int rise, pulses;
    start_run(1'b1, to_redun(to_mont(2)), to_redun(to_mont(3)), 8'd3, 2, 0);
    wait_done(rise, pulses);
    n_checks++;
    if (from_redun(o_res_data) !== to_mont(54)) begin
      n_fail++; $display("FAIL mul_data: got %h want %h", from_redun(o_res_data), to_mont(54));
    end
    n_checks++;
    if (rise !== 10) begin n_fail++; $display("FAIL mul_cycle: got %0d want 10", rise); end
    accept_result();
  endtask

  task automatic test_overflow();
    int rise, pulses, extra;
    start_run(1'b0, to_redun(to_mont(7)), '0, 8'd8, 3, 2);
    wait_done(rise, pulses);
    n_checks++;
    if (o_res_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", o_res_err); end
    n_checks++;
    if (o_iter_done !== 8'd2) begin n_fail++; $display("FAIL ovf_iter: got %0d want 2", o_iter_done); end
    n_checks++;
    if (rise !== 9) begin n_fail++; $display("FAIL ovf_cycle: got %0d want 9", rise); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      if (o_mul_val) extra++;
    end
    n_checks++;
    if (pulses + extra !== 2) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 2", pulses + extra); end
    accept_result();
  endtask

  task automatic test_max_iter();
    int rise, pulses;
    start_run(1'b1, to_redun(to_mont(1)), to_redun(to_mont(2)), 8'd255, 1, 0);
    wait_done(rise, pulses);
    n_checks++;
    if (o_iter_done !== 8'd255) begin n_fail++; $display("FAIL max_iter: got %0d want 255", o_iter_done); end
    n_checks++;
    if (from_redun(o_res_data) !== to_mont(pow2(255))) begin
      n_fail++; $display("FAIL max_data: got %h want %h", from_redun(o_res_data), to_mont(pow2(255)));
    end
    n_checks++;
    if (rise !== 511 || o_res_err !== 1'b0) begin
      n_fail++; $display("FAIL max_cycle_err: got cycle %0d err %b want 511 0", rise, o_res_err);
    end
    accept_result();
  endtask

  task automatic test_back_pressure();
    int rise, pulses, bad;
    logic [W-1:0] exp_res;
    exp_res = to_mont(25);
    start_run(1'b0, to_redun(to_mont(5)), '0, 8'd1, 2, 0);
    wait_done(rise, pulses);
    n_checks++;
    if (rise !== 4) begin n_fail++; $display("FAIL bp_cycle: got %0d want 4", rise); end
    bad = 0;
    i_start_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (o_res_val !== 1'b1 || o_start_rdy !== 1'b0 || from_redun(o_res_data) !== exp_res) bad++;
    end
    i_start_val = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL bp_hold: got %0d unstable cycles (val=%b rdy=%b data=%h) want 0",
                         bad, o_res_val, o_start_rdy, o_res_data);
    end
    accept_result();
    #1;
    n_checks++;
    if (o_start_rdy !== 1'b1 || o_busy !== 1'b0 || o_res_val !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got rdy=%b busy=%b val=%b want 1 0 0", o_start_rdy, o_busy, o_res_val);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    start_run(1'b0, to_redun(to_mont(3)), '0, 8'd5, 8, 0);
    repeat (3) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_start_rdy !== 1'b0 || o_mul_a !== '0 || o_mul_b !== '0) begin
      n_fail++; $display("FAIL rst_async: got busy=%b rdy=%b mul_a=%h mul_b=%h want 0",
                         o_busy, o_start_rdy, o_mul_a, o_mul_b);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      if (o_busy !== 1'b0 || o_res_val !== 1'b0 || o_mul_val !== 1'b0 || o_iter_done !== '0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL rst_late_product: got %0d disturbed cycles (busy=%b iter=%0d) want 0",
                         bad, o_busy, o_iter_done);
    end
  endtask

  initial begin
    test_reset();
    test_t0();
    test_square();
    test_multiply();
    test_overflow();
    test_max_iter();
    test_back_pressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
